hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RISC-V core; sits beside the forwarding unit and drives the stall, flush and hold enables of the datapath pipeline registers.
- Detects load-use hazards, branch-redirect flushes and multi-cycle data-memory waits, with a memory timeout that halts the core.
- Keeps saturating stall and flush performance counters.

Parameters:
- CNT_W, 32, width of the stall_count and flush_count performance counters.
- MEM_TIMEOUT, 16, maximum consecutive MEM_WAIT cycles before a timeout error; legal range 2..255.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous, active-low reset (asserted when 0).
- id_rs1, input, 5, rs1 of the instruction in ID.
- id_rs2, input, 5, rs2 of the instruction in ID.
- id_uses_rs2, input, 1, the ID instruction reads rs2 (R-type, store, branch).
- ex_mem_read, input, 1, the instruction in EX is a load.
- ex_rd, input, 5, destination register of the instruction in EX.
- ex_branch_taken, input, 1, a branch or jump resolved taken in EX this cycle.
- mem_req, input, 1, the instruction in MEM accesses data memory.
- mem_ready, input, 1, data memory completes the access this cycle.
- pc_write, output, 1, PC register enable.
- if_id_write, output, 1, IF/ID register enable.
- if_id_flush, output, 1, load a NOP into IF/ID.
- id_ex_flush, output, 1, load a bubble (all controls 0) into ID/EX.
- pipe_hold, output, 1, hold the ID/EX, EX/MEM and MEM/WB registers.
- mem_err, output, 1, sticky memory-timeout flag.
- stall_count, output, CNT_W, number of cycles with pc_write=0, excluding the ERR state.
- flush_count, output, CNT_W, number of branch flushes.

Behaviour:
- All state updates on the rising clk edge. Outputs are combinational from the current state and the inputs (Mealy).
- While reset=0:
  - Next state is RUN; counters, wait_cnt and mem_err are cleared.
  - Outputs: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1, pipe_hold=0.
- States are RUN, MEM_WAIT and ERR. Default outputs: pc_write=1, if_id_write=1, flushes=0, pipe_hold=0.
- Load-use hazard (lu) is true when all of the following hold:
  - ex_mem_read=1 and ex_rd!=0;
  - and either ex_rd==id_rs1, or (id_uses_rs2=1 and ex_rd==id_rs2).
- Memory stall (ms) is true when mem_req=1 and mem_ready=0.
- RUN, in priority order:
  1. ms: freeze. pc_write=0, if_id_write=0, pipe_hold=1, no flush. Next state MEM_WAIT, wait_cnt<=1.
  2. ex_branch_taken: pc_write=1 (target), if_id_flush=1, id_ex_flush=1. lu is ignored. flush_count increments.
  3. lu: pc_write=0, if_id_write=0, id_ex_flush=1 (one bubble). The next cycle the load is in MEM, so lu clears naturally.
  4. Otherwise: default outputs.
- MEM_WAIT:
  - If mem_ready=1: release. Apply the RUN rules 2–4 to the current inputs this same cycle. Next state RUN.
  - Else if wait_cnt==MEM_TIMEOUT-1: freeze, set mem_err<=1, next state ERR.
  - Else: freeze, wait_cnt<=wait_cnt+1.
  - A branch that was pending during the freeze stays asserted (EX is held) and is acted on at release.
- ERR: permanent freeze (pc_write=0, if_id_write=0, pipe_hold=1). Exit only via reset. Counters do not increment.
- Counters saturate at all-ones and never wrap. stall_count increments on every non-reset, non-ERR cycle with pc_write=0.
- Reset mid-MEM_WAIT: the next cycle is RUN with wait_cnt cleared.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5 -> for one cycle pc_write=0, if_id_write=0, id_ex_flush=1; stall_count 0->1. Repeat with ex_rd=0 -> no stall.
- rs2 gating: ex_rd=7, id_rs2=7 with id_uses_rs2=0 -> no stall; with id_uses_rs2=1 -> stall.
- Branch over load-use: ex_branch_taken=1 and lu=1 in the same cycle -> pc_write=1, both flushes=1, flush_count=1, stall_count unchanged.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 -> pipe_hold=1 and pc_write=0 for 3 cycles; release on the 4th cycle; stall_count=3; state back to RUN.
- Timeout, MEM_TIMEOUT=4: mem_ready held 0 -> mem_err=1 after the 4th wait cycle; pipeline frozen indefinitely, counters frozen. reset=0 for one cycle -> mem_err=0, counters 0, state RUN.
- Saturation, CNT_W=3: force 9 load-use stalls -> stall_count stays at 7.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline sequencing controller for the 5-stage RISC-V core. Generates the
//   PC / IF-ID enables, the IF-ID and ID-EX flushes and the hold of the back
//   pipeline registers from load-use hazards, taken branches and data-memory
//   waits. A data-memory wait that lasts MEM_TIMEOUT cycles raises a sticky
//   error and freezes the core until reset.
//
// Parameters
//   CNT_W        width of the saturating stall/flush performance counters
//   MEM_TIMEOUT  max consecutive wait cycles before timeout (2..255)
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-low reset
//   id_rs1, id_rs2      source registers of the instruction in ID
//   id_uses_rs2         ID instruction actually reads rs2
//   ex_mem_read, ex_rd  EX instruction is a load / its destination register
//   ex_branch_taken     branch or jump resolved taken in EX
//   mem_req, mem_ready  MEM-stage data access request / completion
//   pc_write            PC register enable
//   if_id_write         IF/ID register enable
//   if_id_flush         load a NOP into IF/ID
//   id_ex_flush         load a bubble into ID/EX
//   pipe_hold           hold ID/EX, EX/MEM and MEM/WB
//   mem_err             sticky memory-timeout flag
//   stall_count         cycles with pc_write=0 (outside reset and ERR)
//   flush_count         branch flushes performed
module hazard_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             pipe_hold,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       mem_err_nxt;
  logic       lu, ms;
  logic       apply_run;
  logic       flush_evt;
  logic       stall_evt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Register x0 is hardwired to zero, so a load targeting it never creates
  // a dependency.
  assign lu = ex_mem_read && (ex_rd != 5'd0) &&
              ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
  assign ms = mem_req && !mem_ready;

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    mem_err_nxt  = mem_err;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    pipe_hold    = 1'b0;
    apply_run    = 1'b0;
    flush_evt    = 1'b0;

    if (!reset) begin
      state_nxt    = RUN;
      wait_cnt_nxt = 8'd0;
      mem_err_nxt  = 1'b0;
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          if (ms) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            pipe_hold    = 1'b1;
            state_nxt    = MEM_WAIT;
            wait_cnt_nxt = 8'd1;
          end else begin
            apply_run = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            // Release: the held EX/ID instructions are resolved this cycle.
            apply_run = 1'b1;
            state_nxt = RUN;
          end else begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_hold   = 1'b1;
            if (wait_cnt == WAIT_LAST) begin
              mem_err_nxt = 1'b1;
              state_nxt   = ERR;
            end else begin
              wait_cnt_nxt = wait_cnt + 8'd1;
            end
          end
        end
        ERR: begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          pipe_hold   = 1'b1;
        end
        default: begin
          state_nxt = RUN;
        end
      endcase

      // Branch redirect wins over load-use: the dependent instruction in ID
      // is on the wrong path and gets flushed anyway.
      if (apply_run) begin
        if (ex_branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          flush_evt   = 1'b1;
        end else if (lu) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
        end
      end
    end
  end

  assign stall_evt = reset && (state != ERR) && !pc_write;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= RUN;
      wait_cnt    <= 8'd0;
      mem_err     <= 1'b0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      mem_err  <= mem_err_nxt;
      if (stall_evt) stall_count <= sat_inc(stall_count);
      if (flush_evt) flush_count <= sat_inc(flush_count);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int CNT_W       = 3;
  localparam int MEM_TIMEOUT = 4;

  logic             clk;
  logic             reset;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             id_uses_rs2, ex_mem_read, ex_branch_taken;
  logic             mem_req, mem_ready;
  logic             pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold;
  logic             mem_err;
  logic [CNT_W-1:0] stall_count, flush_count;

  hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .pipe_hold(pipe_hold), .mem_err(mem_err),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // exp_ctl = {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold};
  // counters are the values visible during the cycle (before its edge).
  typedef struct {
    string      name;
    logic       rst_n;
    logic [4:0] rs1, rs2;
    logic       use2, mrd;
    logic [4:0] rd;
    logic       br, req, rdy;
    logic [4:0] exp_ctl;
    logic       exp_err;
    int         sc, fc;
  } vec_t;

  int total = 0;
  int bad   = 0;

  function automatic vec_t mk(string nm, logic rst_n, logic [4:0] rs1,
                              logic [4:0] rs2, logic use2, logic mrd,
                              logic [4:0] rd, logic br, logic req, logic rdy,
                              logic [4:0] ctl, logic err, int sc, int fc);
    vec_t v;
    v.name = nm; v.rst_n = rst_n; v.rs1 = rs1; v.rs2 = rs2; v.use2 = use2;
    v.mrd = mrd; v.rd = rd; v.br = br; v.req = req; v.rdy = rdy;
    v.exp_ctl = ctl; v.exp_err = err; v.sc = sc; v.fc = fc;
    return v;
  endfunction

  task automatic chk(string nm, string what, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s: got %0h expected %0h", nm, what, act, exp);
    end
  endtask

  task automatic apply(vec_t v, bit check_cnt);
    @(negedge clk);
    reset = v.rst_n; id_rs1 = v.rs1; id_rs2 = v.rs2; id_uses_rs2 = v.use2;
    ex_mem_read = v.mrd; ex_rd = v.rd; ex_branch_taken = v.br;
    mem_req = v.req; mem_ready = v.rdy;
    #2;
    chk(v.name, "ctl", {27'd0, pc_write, if_id_write, if_id_flush,
                        id_ex_flush, pipe_hold}, {27'd0, v.exp_ctl});
    chk(v.name, "mem_err", {31'd0, mem_err}, {31'd0, v.exp_err});
    if (check_cnt) begin
      chk(v.name, "stall_count", {29'd0, stall_count}, v.sc);
      chk(v.name, "flush_count", {29'd0, flush_count}, v.fc);
    end
  endtask

  localparam logic [4:0] C_RST    = 5'b00110;
  localparam logic [4:0] C_RUN    = 5'b11000;
  localparam logic [4:0] C_LU     = 5'b00010;
  localparam logic [4:0] C_BR     = 5'b11110;
  localparam logic [4:0] C_FREEZE = 5'b00001;

  vec_t tbl[13];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //            name       rst rs1 rs2 u2 mrd rd br req rdy ctl       err sc fc
    tbl[0]  = mk("rst",       0,  5,  5, 1, 1,  5, 1, 1, 0, C_RST,    0, 0, 0);
    tbl[1]  = mk("idle",      1,  0,  0, 0, 0,  0, 0, 0, 0, C_RUN,    0, 0, 0);
    tbl[2]  = mk("lu_rs1",    1,  5,  0, 0, 1,  5, 0, 0, 0, C_LU,     0, 0, 0);
    tbl[3]  = mk("idle2",     1,  0,  0, 0, 0,  0, 0, 0, 0, C_RUN,    0, 1, 0);
    tbl[4]  = mk("lu_x0",     1,  0,  0, 0, 1,  0, 0, 0, 0, C_RUN,    0, 1, 0);
    tbl[5]  = mk("rs2_nouse", 1,  3,  7, 0, 1,  7, 0, 0, 0, C_RUN,    0, 1, 0);
    tbl[6]  = mk("rs2_use",   1,  3,  7, 1, 1,  7, 0, 0, 0, C_LU,     0, 1, 0);
    tbl[7]  = mk("br_lu",     1,  5,  0, 0, 1,  5, 1, 0, 0, C_BR,     0, 2, 0);
    tbl[8]  = mk("br",        1,  0,  0, 0, 0,  0, 1, 0, 0, C_BR,     0, 2, 1);
    tbl[9]  = mk("lu_memrdy", 1,  9,  0, 0, 1,  9, 0, 1, 1, C_LU,     0, 2, 2);
    tbl[10] = mk("ms_br",     1,  0,  0, 0, 0,  0, 1, 1, 0, C_FREEZE, 0, 3, 2);
    tbl[11] = mk("rel_br",    1,  0,  0, 0, 0,  0, 1, 1, 1, C_BR,     0, 4, 2);
    tbl[12] = mk("nomrd",     1,  4,  0, 0, 0,  4, 0, 0, 0, C_RUN,    0, 4, 3);

    reset = 1'b0; id_rs1 = '0; id_rs2 = '0; id_uses_rs2 = 1'b0;
    ex_mem_read = 1'b0; ex_rd = '0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 13; i++) apply(tbl[i], 1'b1);

    // Memory wait of three cycles, then release.
    apply(mk("mw_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 0, 4, 3), 1'b1);
    for (int i = 0; i < 3; i++)
      apply(mk("mw_wait", 1, 0, 0, 0, 0, 0, 0, 1, 0, C_FREEZE, 0, i, 0), 1'b1);
    apply(mk("mw_rel",  1, 0, 0, 0, 0, 0, 0, 1, 1, C_RUN, 0, 3, 0), 1'b1);
    apply(mk("mw_after",1, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 3, 0), 1'b1);

    // Timeout: four wait cycles, then ERR ignores ready and branches.
    apply(mk("to_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 0, 3, 0), 1'b1);
    for (int i = 0; i < 4; i++)
      apply(mk("to_wait", 1, 0, 0, 0, 0, 0, 0, 1, 0, C_FREEZE, 0, i, 0), 1'b1);
    for (int i = 0; i < 3; i++)
      apply(mk("to_err", 1, 5, 0, 0, 1, 5, 1, 1, 1, C_FREEZE, 1, 4, 0), 1'b1);
    apply(mk("to_clr", 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 1, 4, 0), 1'b1);
    apply(mk("to_run", 1, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 0, 0), 1'b1);

    // Reset in the middle of a wait restarts the timeout window from RUN.
    apply(mk("mr_wait", 1, 0, 0, 0, 0, 0, 0, 1, 0, C_FREEZE, 0, 0, 0), 1'b1);
    apply(mk("mr_wait", 1, 0, 0, 0, 0, 0, 0, 1, 0, C_FREEZE, 0, 1, 0), 1'b1);
    apply(mk("mr_rst",  0, 0, 0, 0, 0, 0, 0, 1, 0, C_RST, 0, 2, 0), 1'b1);
    for (int i = 0; i < 3; i++)
      apply(mk("mr_wait2", 1, 0, 0, 0, 0, 0, 0, 1, 0, C_FREEZE, 0, i, 0), 1'b1);
    apply(mk("mr_rel",  1, 0, 0, 0, 0, 0, 0, 1, 1, C_RUN, 0, 3, 0), 1'b1);

    // Saturation: nine load-use stalls on a 3-bit counter.
    apply(mk("sat_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 0, 3, 0), 1'b1);
    for (int i = 0; i < 9; i++)
      apply(mk("sat_lu", 1, 6, 0, 0, 1, 6, 0, 0, 0, C_LU, 0,
               (i > 7) ? 7 : i, 0), 1'b1);
    apply(mk("sat_end", 1, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 7, 0), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
